trigger_capture: RTL and testbench

- Downstream of the mouse user interface. Consumes its count_adc (sample decimation), trigger (level) and trig_clk (holdoff) settings.
- Decimates the ADC sample stream and detects level crossings on the decimated stream.
- Writes one DEPTH-sample frame per trigger into the display sample buffer. The chart renderer reads that buffer.

---
 rtl/trigger_capture_if.sv | 35 +++
 rtl/trigger_capture.sv | 146 ++++++++++++++
 tb/tb_trigger_capture.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_capture_if.sv
// Bundle of the trigger/capture control inputs, ADC stream and buffer write port.
// The master side (settings UI / ADC / bench) drives inputs; the slave is the capture engine.
interface trigger_capture_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
);
  logic              adc_valid;
  logic [DATA_W-1:0] adc_data;
  logic [11:0]       count_adc;
  logic [DATA_W-1:0] trigger;
  logic [11:0]       trig_clk;
  logic              trig_edge;
  logic              single;
  logic              arm;
  logic              force_trig;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              frame_done;
  logic              busy;
  logic [1:0]        state_dbg;

  modport master (
    output adc_valid, adc_data, count_adc, trigger, trig_clk,
           trig_edge, single, arm, force_trig,
    input  wr_en, wr_addr, wr_data, frame_done, busy, state_dbg
  );

  modport slave (
    input  adc_valid, adc_data, count_adc, trigger, trig_clk,
           trig_edge, single, arm, force_trig,
    output wr_en, wr_addr, wr_data, frame_done, busy, state_dbg
  );
endinterface

// File: rtl/trigger_capture.sv
// Decimates the ADC stream, detects level crossings and writes one DEPTH-sample
// frame per trigger into the display sample buffer, followed by a holdoff.
module trigger_capture #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
) (
  input logic               clk,
  input logic               rst_n,
  trigger_capture_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    HOLDOFF = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state_q;
  logic [11:0]       dec_cnt_q;
  logic [DATA_W-1:0] prev_q;
  logic              prev_ok_q;
  logic              pend_q;
  logic [ADDR_W-1:0] wr_idx_q;
  logic [11:0]       ho_cnt_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              frame_done_q;

  logic [11:0] period;
  logic [12:0] dec_next;
  logic        tick;
  logic        edge_hit;
  logic        trig_hit;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    period   = (bus.count_adc == '0) ? 12'd1 : bus.count_adc;
    dec_next = {1'b0, dec_cnt_q} + 13'd1;
    tick     = bus.adc_valid && (dec_next >= {1'b0, period});
    edge_hit = 1'b0;
    if (bus.trig_edge) begin
      edge_hit = prev_ok_q && (prev_q < bus.trigger) && (bus.adc_data >= bus.trigger);
    end else begin
      edge_hit = prev_ok_q && (prev_q > bus.trigger) && (bus.adc_data <= bus.trigger);
    end
    trig_hit = tick && (edge_hit || pend_q || bus.force_trig);
  end

  // The >= compare lets a lowered count_adc tick on the very next strobe.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt_q <= '0;
    end else if (bus.adc_valid) begin
      dec_cnt_q <= tick ? 12'd0 : dec_next[11:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      prev_ok_q    <= 1'b0;
      pend_q       <= 1'b0;
      wr_idx_q     <= '0;
      ho_cnt_q     <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (tick) begin
        prev_q <= bus.adc_data;
      end

      unique case (state_q)
        IDLE: begin
          if (!bus.single || bus.arm) begin
            state_q   <= ARMED;
            prev_ok_q <= 1'b0;
            pend_q    <= 1'b0;
          end
        end

        ARMED: begin
          if (bus.force_trig) begin
            pend_q <= 1'b1;
          end
          if (tick) begin
            prev_ok_q <= 1'b1;
          end
          if (trig_hit) begin
            state_q   <= CAPTURE;
            pend_q    <= 1'b0;
            wr_en_q   <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= bus.adc_data;
            wr_idx_q  <= {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end

        CAPTURE: begin
          if (tick) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= wr_idx_q;
            wr_data_q <= bus.adc_data;
            wr_idx_q  <= wr_idx_q + 1'b1;
            if (wr_idx_q == LAST_ADDR) begin
              state_q      <= HOLDOFF;
              frame_done_q <= 1'b1;
              ho_cnt_q     <= '0;
            end
          end
        end

        HOLDOFF: begin
          // trig_clk==0 satisfies the compare immediately and leaves on the first clock.
          if (ho_cnt_q >= bus.trig_clk) begin
            ho_cnt_q  <= '0;
            state_q   <= bus.single ? IDLE : ARMED;
            prev_ok_q <= 1'b0;
            pend_q    <= 1'b0;
          end else if (tick) begin
            ho_cnt_q <= ho_cnt_q + 12'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Directed testbench for trigger_capture: reset abort, decimation, rising/falling
// triggers, forced one-shot capture with holdoff, and auto re-arm.
module tb_trigger_capture;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LOG_N  = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trigger_capture_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  trigger_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Write-port monitor: samples on the falling edge, away from the active edge.
  logic              mon_clr = 1'b0;
  int                n_wr, n_fd, fd_addr, fd_wr, order_err;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] log_addr [LOG_N];
  logic [DATA_W-1:0] log_data [LOG_N];
  logic [DATA_W-1:0] save_data [DEPTH];

  always @(negedge clk) begin
    if (mon_clr) begin
      n_wr = 0; n_fd = 0; fd_addr = -1; fd_wr = 0; order_err = 0; last_addr = '0;
    end else if (rst_n) begin
      if (bus.wr_en) begin
        if (n_wr > 0 && bus.wr_addr != last_addr + 1'b1) order_err++;
        if (n_wr < LOG_N) begin
          log_addr[n_wr] = bus.wr_addr;
          log_data[n_wr] = bus.wr_data;
        end
        last_addr = bus.wr_addr;
        n_wr++;
      end
      if (bus.frame_done) begin
        n_fd++;
        fd_addr = int'(bus.wr_addr);
        fd_wr   = int'(bus.wr_en);
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic push(input int d, input bit a);
    bus.adc_valid = 1'b1;
    bus.adc_data  = d[DATA_W-1:0];
    bus.arm       = a;
    @(posedge clk); #1;
    bus.adc_valid = 1'b0;
    bus.arm       = 1'b0;
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1;
    @(posedge clk); #1;
    bus.arm = 1'b0;
  endtask

  task automatic pulse_force();
    bus.force_trig = 1'b1;
    @(posedge clk); #1;
    bus.force_trig = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    clear_mon();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic config_dut(input int cnt, input bit sgl, input int lvl, input bit edg, input int ho);
    bus.count_adc = cnt[11:0];
    bus.single    = sgl;
    bus.trigger   = lvl[DATA_W-1:0];
    bus.trig_edge = edg;
    bus.trig_clk  = ho[11:0];
  endtask

  function automatic int sine_s(input int i);
    return int'(2048.0 + 2047.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 64.0));
  endfunction

  // Ramp with one tick per strobe until frame_done; used by the count_adc 0/1 runs.
  task automatic run_unit_ramp(input int cnt);
    int i;
    int err;
    config_dut(cnt, 1'b0, 2048, 1'b1, 0);
    do_reset();
    i = 0;
    while (!bus.frame_done && i < 3000) begin
      push((16 * i) % 4096, 1'b0);
      i++;
    end
    check($sformatf("t3_done_c%0d", cnt), int'(bus.frame_done), 1);
    idle(2);
    check($sformatf("t3_nwr_c%0d", cnt), n_wr, DEPTH);
    err = 0;
    for (int j = 0; j < DEPTH; j++)
      if (int'(log_data[j]) != (2048 + 16 * j) % 4096) err++;
    check($sformatf("t3_data_c%0d", cnt), err, 0);
  endtask

  initial begin
    int i;
    int err;
    bus.adc_valid = 1'b0; bus.adc_data = '0; bus.arm = 1'b0; bus.force_trig = 1'b0;
    config_dut(1, 1'b1, 0, 1'b1, 0);
    rst_n = 1'b0;
    idle(2);

    // Reset state
    check("rst_wr_en", int'(bus.wr_en), 0);
    check("rst_wr_addr", int'(bus.wr_addr), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_state", int'(bus.state_dbg), 0);

    // 1: async reset mid-capture at address 300
    config_dut(1, 1'b0, 2048, 1'b1, 0);
    do_reset();
    i = 0;
    while (!(bus.wr_en && bus.wr_addr == 10'd300) && i < 2000) begin
      push((16 * i) % 4096, 1'b0);
      i++;
    end
    check("t1_reach300", int'(bus.wr_addr), 300);
    #2 rst_n = 1'b0;
    #1;
    check("t1_wr_en", int'(bus.wr_en), 0);
    check("t1_wr_addr", int'(bus.wr_addr), 0);
    check("t1_wr_data", int'(bus.wr_data), 0);
    check("t1_fd", int'(bus.frame_done), 0);
    check("t1_busy", int'(bus.busy), 0);
    bus.single = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t1_state", int'(bus.state_dbg), 0);
    for (int k = 0; k < 200; k++) push((16 * k) % 4096, 1'b0);
    idle(1);
    check("t1_no_wr", n_wr, 0);

    // 2: count_adc=4, rising 2048, ramp step 16 phased so ticks land on multiples of 64
    config_dut(4, 1'b0, 2048, 1'b1, 5);
    do_reset();
    i = 0;
    while (!bus.frame_done && i < 6000) begin
      push((16 * i + 16) % 4096, 1'b0);
      i++;
    end
    check("t2_done", int'(bus.frame_done), 1);
    idle(2);
    check("t2_nwr", n_wr, DEPTH);
    check("t2_addr0", int'(log_addr[0]), 0);
    check("t2_data0", int'(log_data[0]), 2048);
    check("t2_data_last", int'(log_data[DEPTH-1]), 1984);
    check("t2_nfd", n_fd, 1);
    check("t2_fd_addr", fd_addr, DEPTH - 1);
    check("t2_fd_wr", fd_wr, 1);
    check("t2_order", order_err, 0);
    err = 0;
    for (int j = 0; j < DEPTH; j++)
      if (int'(log_data[j]) != (2048 + 64 * j) % 4096) err++;
    check("t2_data", err, 0);

    // 3: count_adc=0 behaves exactly like count_adc=1
    run_unit_ramp(0);
    for (int j = 0; j < DEPTH; j++) save_data[j] = log_data[j];
    run_unit_ramp(1);
    err = 0;
    for (int j = 0; j < DEPTH; j++)
      if (save_data[j] != log_data[j]) err++;
    check("t3_same", err, 0);

    // 4: falling edge at 1000 on a sine starting at its trough
    config_dut(1, 1'b1, 1000, 1'b0, 0);
    do_reset();
    pulse_arm();
    i = 0;
    while (!bus.wr_en && i < 400) begin
      push(sine_s(48 + i), 1'b0);
      i++;
    end
    check("t4_wr_en", int'(bus.wr_en), 1);
    check("t4_addr0", int'(bus.wr_addr), 0);
    check("t4_data0", int'(bus.wr_data), 911);
    check("t4_push_idx", i, 55);

    // 5: one-shot forced capture, holdoff of 10 ticks, re-arm required
    config_dut(2, 1'b1, 3000, 1'b1, 10);
    do_reset();
    idle(2);
    check("t5_idle", int'(bus.state_dbg), 0);
    pulse_arm();
    check("t5_armed", int'(bus.state_dbg), 1);
    for (int k = 0; k < 20; k++) push(500, 1'b0);
    idle(1);
    check("t5_no_level_trig", n_wr, 0);
    pulse_force();
    push(500, 1'b0);
    check("t5_not_yet", int'(bus.wr_en), 0);
    push(500, 1'b0);
    check("t5_wr_en", int'(bus.wr_en), 1);
    check("t5_addr0", int'(bus.wr_addr), 0);
    check("t5_data0", int'(bus.wr_data), 500);
    check("t5_capture", int'(bus.state_dbg), 2);
    i = 0;
    while (!bus.frame_done && i < 3000) begin
      push(500, 1'b0);
      i++;
    end
    check("t5_done", int'(bus.frame_done), 1);
    for (int k = 0; k < 19; k++) push(500, 1'b0);
    idle(2);
    check("t5_holdoff", int'(bus.state_dbg), 3);
    push(500, 1'b0);
    idle(2);
    check("t5_back_idle", int'(bus.state_dbg), 0);
    idle(1);
    check("t5_nwr", n_wr, DEPTH);
    clear_mon();
    for (int k = 0; k < 20; k++) push(500, 1'b0);
    pulse_force();
    for (int k = 0; k < 20; k++) push(500, 1'b0);
    idle(1);
    check("t5_no_rearm", n_wr, 0);
    pulse_arm();
    pulse_force();
    push(500, 1'b0);
    push(500, 1'b0);
    check("t5_second_wr", int'(bus.wr_en), 1);
    check("t5_second_addr", int'(bus.wr_addr), 0);

    // 6: auto re-arm with zero holdoff; arm pulses during capture are ignored
    config_dut(1, 1'b0, 2048, 1'b1, 0);
    do_reset();
    i = 0;
    while (!bus.frame_done && i < 3000) begin
      push((16 * i) % 4096, (i % 50) == 49);
      i++;
    end
    check("t6_done", int'(bus.frame_done), 1);
    check("t6_holdoff", int'(bus.state_dbg), 3);
    @(posedge clk); #1;
    check("t6_rearmed", int'(bus.state_dbg), 1);
    idle(1);
    check("t6_nwr", n_wr, DEPTH);
    check("t6_order", order_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
